// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and constants for the two-requester BRAM port arbiter.
package bram_port_arbiter_pkg;

    localparam int unsigned REQ_NUM           = 2;
    localparam int unsigned ID_W              = 1;
    localparam int unsigned READ_LATENCY_LOW  = 1;
    localparam int unsigned READ_LATENCY_HIGH = 2;

    // In-flight read tag: which requester the returning RAM data belongs to
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter_2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, pointer flips after every grant.
module rr_arbiter_2
    import bram_port_arbiter_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [REQ_NUM-1:0] req,
    output logic [REQ_NUM-1:0] grant_c
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_c = '0;
        ptr_d   = ptr_q;
        if (req == 2'b11) begin
            grant_c = ptr_q ? 2'b10 : 2'b01;
        end else begin
            grant_c = req;
        end
        // Point at the requester that did not win
        if (|grant_c) begin
            ptr_d = grant_c[0];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between two requesters; reads return after READ_LATENCY cycles in grant order.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int unsigned RAM_WIDTH    = 18,
    parameter int unsigned RAM_DEPTH    = 1024,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [REQ_NUM-1:0]           req_valid,
    output logic [REQ_NUM-1:0]           req_ready,
    input  logic [REQ_NUM-1:0]           req_we,
    input  logic [$clog2(RAM_DEPTH)-1:0] req_addr0,
    input  logic [$clog2(RAM_DEPTH)-1:0] req_addr1,
    input  logic [RAM_WIDTH-1:0]         req_wdata0,
    input  logic [RAM_WIDTH-1:0]         req_wdata1,
    output logic [REQ_NUM-1:0]           rsp_valid,
    output logic [RAM_WIDTH-1:0]         rsp_data,
    output logic [$clog2(RAM_DEPTH)-1:0] ram_addra,
    output logic [RAM_WIDTH-1:0]         ram_dina,
    output logic                         ram_wea,
    output logic                         ram_ena,
    output logic                         ram_regcea,
    output logic                         ram_rsta,
    input  logic [RAM_WIDTH-1:0]         ram_douta
);

    localparam int unsigned ADDR_W    = $clog2(RAM_DEPTH);
    localparam int unsigned TAG_DEPTH = (READ_LATENCY == READ_LATENCY_LOW) ? READ_LATENCY_LOW
                                                                           : READ_LATENCY_HIGH;

    logic [REQ_NUM-1:0] req_gated_c;
    logic [REQ_NUM-1:0] grant_c;
    logic               gnt_id_c;
    tag_t               tag_q [TAG_DEPTH];
    tag_t               tag_d [TAG_DEPTH];

    // No grants while reset is held
    assign req_gated_c = req_valid & {REQ_NUM{~rst_in}};

    rr_arbiter_2 u_rr (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .req     (req_gated_c),
        .grant_c (grant_c)
    );

    // Granted request drives the RAM port directly; nothing is latched
    always_comb begin
        gnt_id_c  = grant_c[1];
        req_ready = grant_c;
        ram_ena   = |grant_c;
        ram_wea   = (|grant_c) & req_we[gnt_id_c];
        ram_addra = gnt_id_c ? req_addr1 : req_addr0;
        ram_dina  = gnt_id_c ? req_wdata1 : req_wdata0;
    end

    assign ram_regcea = 1'b1;
    assign ram_rsta   = rst_in;

    // Only reads enter the tag pipe, so write read-first data is never returned
    always_comb begin
        for (int i = 0; i < int'(TAG_DEPTH); i++) begin
            tag_d[i] = '0;
        end
        tag_d[0].valid = ram_ena & ~ram_wea;
        tag_d[0].id    = ID_W'(gnt_id_c);
        for (int i = 1; i < int'(TAG_DEPTH); i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(TAG_DEPTH); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(TAG_DEPTH); i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (tag_q[TAG_DEPTH-1].valid) begin
            rsp_valid[tag_q[TAG_DEPTH-1].id] = 1'b1;
        end
        rsp_data = ram_douta;
    end

    logic unused_addr_w;
    assign unused_addr_w = (ADDR_W == 0);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench: latency-2 and latency-1 arbiters share stimulus, checked against a queue-based model.
module tb_bram_port_arbiter;
    localparam int unsigned RW    = 18;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 10;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [1:0]    req_valid, req_we;
    logic [AW-1:0] req_addr0, req_addr1;
    logic [RW-1:0] req_wdata0, req_wdata1;

    logic [1:0]    rdy2, rv2, rdy1, rv1;
    logic [RW-1:0] rd2, rd1, dina2, dina1, douta2, douta1;
    logic [AW-1:0] addra2, addra1;
    logic          wea2, ena2, regcea2, rsta2, wea1, ena1, regcea1, rsta1;

    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [RW-1:0] pl_data;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    bram_port_arbiter #(.RAM_WIDTH(RW), .RAM_DEPTH(DEPTH), .READ_LATENCY(2)) u_dut2 (
        .clk_in(clk_in), .rst_in(rst_in), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rv2), .rsp_data(rd2), .ram_addra(addra2), .ram_dina(dina2), .ram_wea(wea2),
        .ram_ena(ena2), .ram_regcea(regcea2), .ram_rsta(rsta2), .ram_douta(douta2));

    bram_port_arbiter #(.RAM_WIDTH(RW), .RAM_DEPTH(DEPTH), .READ_LATENCY(1)) u_dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rv1), .rsp_data(rd1), .ram_addra(addra1), .ram_dina(dina1), .ram_wea(wea1),
        .ram_ena(ena1), .ram_regcea(regcea1), .ram_rsta(rsta1), .ram_douta(douta1));

    // Read-first BRAM models: latency 2 uses the output register, latency 1 does not
    logic [RW-1:0] ram2 [DEPTH];
    logic [RW-1:0] ram1 [DEPTH];
    logic [RW-1:0] ram2_rd;

    always @(posedge clk_in) begin
        if (pl_en) ram2[pl_addr] <= pl_data;
        else if (ena2) begin
            ram2_rd <= ram2[addra2];
            if (wea2) ram2[addra2] <= dina2;
        end
        douta2 <= ram2_rd;
    end

    always @(posedge clk_in) begin
        if (pl_en) ram1[pl_addr] <= pl_data;
        else if (ena1) begin
            douta1 <= ram1[addra1];
            if (wea1) ram1[addra1] <= dina1;
        end
    end

    typedef struct packed {
        logic [1:0]    ready2;
        logic [1:0]    ready1;
        logic [1:0]    ena;
        logic [1:0]    wea;
        logic [AW-1:0] addr;
        logic [RW-1:0] din;
        logic [1:0]    rv2;
        logic [RW-1:0] rd2;
        logic [1:0]    rv1;
        logic [RW-1:0] rd1;
        logic [1:0]    rsta;
        logic [1:0]    regcea;
    } obs_t;

    typedef struct {
        int            due;
        logic          id;
        logic [RW-1:0] data;
    } pend_t;

    // Reference model: abstract memory, round-robin pointer, queues of responses due per latency
    logic [RW-1:0] mdl_mem [DEPTH];
    pend_t         q1[$];
    pend_t         q2[$];
    int            m_ptr = 0;

    function automatic obs_t model_cycle();
        obs_t e = '0;
        int   g;
        e.rsta   = {rst_in, rst_in};
        e.regcea = 2'b11;
        if (rst_in) begin
            m_ptr = 0;
            q1.delete();
            q2.delete();
            return e;
        end
        if (q2.size() != 0 && q2[0].due == cyc) begin
            e.rv2 = q2[0].id ? 2'b10 : 2'b01;
            e.rd2 = q2[0].data;
            void'(q2.pop_front());
        end
        if (q1.size() != 0 && q1[0].due == cyc) begin
            e.rv1 = q1[0].id ? 2'b10 : 2'b01;
            e.rd1 = q1[0].data;
            void'(q1.pop_front());
        end
        if (req_valid == 2'b11) g = m_ptr;
        else if (req_valid[0]) g = 0;
        else if (req_valid[1]) g = 1;
        else g = -1;
        if (g >= 0) begin
            e.ready2 = (g == 1) ? 2'b10 : 2'b01;
            e.ready1 = e.ready2;
            e.ena    = 2'b11;
            e.addr   = (g == 1) ? req_addr1 : req_addr0;
            e.din    = (g == 1) ? req_wdata1 : req_wdata0;
            if (req_we[g]) begin
                e.wea = 2'b11;
                mdl_mem[e.addr] = e.din;
            end else begin
                q2.push_back('{due: cyc + 2, id: (g == 1), data: mdl_mem[e.addr]});
                q1.push_back('{due: cyc + 1, id: (g == 1), data: mdl_mem[e.addr]});
            end
            m_ptr = 1 - g;
        end
        return e;
    endfunction

    function automatic obs_t sample_dut();
        obs_t o = '0;
        o.ready2 = rdy2;
        o.ready1 = rdy1;
        o.ena    = {ena2, ena1};
        o.wea    = {wea2, wea1};
        if (ena2) begin
            o.addr = addra2;
            o.din  = dina2;
        end
        o.rv2 = rv2;
        if (rv2 != 2'b00) o.rd2 = rd2;
        o.rv1 = rv1;
        if (rv1 != 2'b00) o.rd1 = rd1;
        o.rsta   = {rsta2, rsta1};
        o.regcea = {regcea2, regcea1};
        return o;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic [RW-1:0] d0, input logic [RW-1:0] d1);
        tick();
        rst_in     = 1'b0;
        pl_en      = 1'b0;
        req_valid  = v;
        req_we     = we;
        req_addr0  = a0;
        req_addr1  = a1;
        req_wdata0 = d0;
        req_wdata1 = d1;
    endtask

    task automatic hold_reset();
        tick();
        rst_in    = 1'b1;
        req_valid = 2'b00;
        pl_en     = 1'b0;
        m_ptr     = 0;
        q1.delete();
        q2.delete();
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [RW-1:0] d);
        tick();
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        mdl_mem[a] = d;
    endtask

    task automatic test_reset();
        obs_t e, o;
        for (int k = 0; k < 3; k++) begin
            tick();
            rst_in = 1'b1; req_valid = 2'b11; req_we = 2'b00;
            req_addr0 = 10'h001; req_addr1 = 10'h002;
            @(negedge clk_in);
            e = model_cycle(); o = sample_dut();
            n_total++;
            if (o !== e) $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
            n_total++;
            if ({rdy2, rv2, ena2, wea2, rdy1, rv1, ena1, wea1} !== 12'h000)
                $display("FAIL reset_outputs cyc=%0d got=%h exp=000", cyc,
                         {rdy2, rv2, ena2, wea2, rdy1, rv1, ena1, wea1});
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        obs_t e, o;
        hold_reset();
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: drive(2'b01, 2'b01, 10'h005, '0, 18'h0002A, '0);
                1: drive(2'b01, 2'b00, 10'h005, '0, '0, '0);
                default: drive(2'b00, 2'b00, '0, '0, '0, '0);
            endcase
            @(negedge clk_in);
            e = model_cycle(); o = sample_dut();
            n_total++;
            if (o !== e) $display("FAIL write_read_model cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
            if (k == 2) begin
                n_total++;
                if (rv2 !== 2'b00 || rv1 !== 2'b01 || rd1 !== 18'h0002A)
                    $display("FAIL write_read_k2 rv2=%b rv1=%b rd1=%h exp rv2=00 rv1=01 rd1=0002a", rv2, rv1, rd1);
                else n_pass++;
            end
            if (k == 3) begin
                n_total++;
                if (rv2 !== 2'b01 || rd2 !== 18'h0002A)
                    $display("FAIL write_read_rsp rv2=%b rd2=%h exp rv2=01 rd2=0002a", rv2, rd2);
                else n_pass++;
            end
        end
    endtask

    task automatic test_contention();
        obs_t e, o;
        hold_reset();
        preload(10'h010, 18'h00111);
        preload(10'h020, 18'h00222);
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(2'b11, 2'b00, 10'h010, 10'h020, '0, '0);
            else drive(2'b00, 2'b00, '0, '0, '0, '0);
            @(negedge clk_in);
            e = model_cycle(); o = sample_dut();
            n_total++;
            if (o !== e) $display("FAIL contention_model cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
            if (k < 4) begin
                n_total++;
                if (rdy2 !== ((k % 2 == 1) ? 2'b10 : 2'b01))
                    $display("FAIL contention_grant k=%0d got=%b exp=%b", k, rdy2, (k % 2 == 1) ? 2'b10 : 2'b01);
                else n_pass++;
            end
            if (k >= 2) begin
                n_total++;
                if (rv2 !== ((k % 2 == 1) ? 2'b10 : 2'b01) || rd2 !== ((k % 2 == 1) ? 18'h00222 : 18'h00111))
                    $display("FAIL contention_rsp k=%0d rv2=%b rd2=%h", k, rv2, rd2);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        hold_reset();
        for (int a = 0; a < 8; a++) preload(AW'(a), RW'(3 * a));
        for (int k = 0; k < 11; k++) begin
            if (k < 8) drive(2'b10, 2'b00, '0, AW'(k), '0, '0);
            else drive(2'b00, 2'b00, '0, '0, '0, '0);
            @(negedge clk_in);
            e = model_cycle(); o = sample_dut();
            n_total++;
            if (o !== e) $display("FAIL b2b_model cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
            if (k >= 2) begin
                n_total++;
                if (k < 10 && (rv2 !== 2'b10 || rd2 !== RW'(3 * (k - 2))))
                    $display("FAIL b2b_rsp k=%0d rv2=%b rd2=%h exp rv2=10 rd2=%h", k, rv2, rd2, RW'(3 * (k - 2)));
                else if (k == 10 && rv2 !== 2'b00)
                    $display("FAIL b2b_tail k=%0d rv2=%b exp=00", k, rv2);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_inflight();
        obs_t e, o;
        hold_reset();
        preload(10'h033, 18'h01234);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive(2'b01, 2'b00, 10'h033, '0, '0, '0);
            else drive(2'b00, 2'b00, '0, '0, '0, '0);
            if (k == 1) rst_in = 1'b1;
            @(negedge clk_in);
            e = model_cycle(); o = sample_dut();
            n_total++;
            if (o !== e) $display("FAIL rst_inflight_model cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
            if (k >= 1) begin
                n_total++;
                if (rv2 !== 2'b00 || rv1 !== 2'b00)
                    $display("FAIL rst_inflight_rsp k=%0d rv2=%b rv1=%b exp 00 00", k, rv2, rv1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_low_latency();
        obs_t e, o;
        hold_reset();
        preload(10'h3FF, 18'h3FFFF);
        for (int k = 0; k < 3; k++) begin
            if (k == 0) drive(2'b01, 2'b00, 10'h3FF, '0, '0, '0);
            else drive(2'b00, 2'b00, '0, '0, '0, '0);
            @(negedge clk_in);
            e = model_cycle(); o = sample_dut();
            n_total++;
            if (o !== e) $display("FAIL low_lat_model cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
            if (k == 1) begin
                n_total++;
                if (rv1 !== 2'b01 || rd1 !== 18'h3FFFF || rv2 !== 2'b00)
                    $display("FAIL low_lat_rsp rv1=%b rd1=%h rv2=%b exp rv1=01 rd1=3ffff rv2=00", rv1, rd1, rv2);
                else n_pass++;
            end
        end
    endtask

    task automatic test_write_read_same();
        obs_t e, o;
        hold_reset();
        preload(10'h007, 18'h00000);
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: drive(2'b11, 2'b01, 10'h007, 10'h007, 18'h000AA, '0);
                1: drive(2'b10, 2'b00, '0, 10'h007, '0, '0);
                default: drive(2'b00, 2'b00, '0, '0, '0, '0);
            endcase
            @(negedge clk_in);
            e = model_cycle(); o = sample_dut();
            n_total++;
            if (o !== e) $display("FAIL same_addr_model cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
            if (k < 2) begin
                n_total++;
                if (rdy2 !== ((k == 0) ? 2'b01 : 2'b10) || wea2 !== (k == 0))
                    $display("FAIL same_addr_grant k=%0d rdy=%b wea=%b", k, rdy2, wea2);
                else n_pass++;
            end
            if (k == 3) begin
                n_total++;
                if (rv2 !== 2'b10 || rd2 !== 18'h000AA)
                    $display("FAIL same_addr_rsp rv2=%b rd2=%h exp rv2=10 rd2=000aa", rv2, rd2);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        obs_t          e, o;
        logic [1:0]    pv, pwe;
        logic [AW-1:0] pa [2];
        logic [RW-1:0] pd [2];
        hold_reset();
        for (int a = 0; a < 16; a++) preload(AW'(a), RW'($urandom));
        pv = 2'b00; pwe = 2'b00;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i]) begin
                    pv[i]  = ($urandom_range(0, 9) < 6);
                    pwe[i] = $urandom_range(0, 1) == 1;
                    pa[i]  = AW'($urandom_range(0, 15));
                    pd[i]  = RW'($urandom);
                end
            end
            drive(pv, pwe, pa[0], pa[1], pd[0], pd[1]);
            if ($urandom_range(0, 49) == 0) rst_in = 1'b1;
            @(negedge clk_in);
            e = model_cycle(); o = sample_dut();
            n_total++;
            if (o !== e) $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
            pv = pv & ~e.ready2;
        end
        drive(2'b00, 2'b00, '0, '0, '0, '0);
    endtask

    initial begin
        rst_in = 1'b1; req_valid = 2'b00; req_we = 2'b00;
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        test_reset();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_reset_inflight();
        test_low_latency();
        test_write_read_same();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
